// File: rtl/fpga_config_loader.sv
// Byte-serial configuration loader: SYNC header, 354 payload bytes staged in a shadow
// register, then an XOR checksum byte that gates the commit into the active select vectors.
module fpga_config_loader #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [7:0]     cfg_data,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    output logic [899:0]   brbselect,
    output logic [1727:0]  bsbselect,
    output logic [79:0]    lbselect,
    output logic [29:0]    leftioselect,
    output logic [29:0]    rightioselect,
    output logic [29:0]    topioselect,
    output logic [29:0]    bottomioselect,
    output logic           cfg_busy,
    output logic           cfg_done,
    output logic           cfg_error,
    output logic           configured
);

    localparam int         P_BITS    = 2828;
    localparam int         N_BYTES   = 354;
    localparam logic [8:0] LAST_BYTE = 9'd353;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_DONE,
        S_ERR
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [P_BITS-1:0] r_shadow;
    logic [P_BITS-1:0] r_active;
    logic [8:0]        r_count;
    logic [7:0]        r_xor;
    logic              r_busy;
    logic              r_configured;
    logic              w_accept;
    logic              w_load_we;
    logic              w_commit;

    assign cfg_ready = !rst && (r_state != S_DONE) && (r_state != S_ERR);
    assign w_accept  = cfg_valid && cfg_ready;
    assign w_load_we = w_accept && (r_state == S_LOAD);
    assign w_commit  = w_accept && (r_state == S_CHECK) && (cfg_data == r_xor);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && cfg_data == SYNC_BYTE) w_state_next = S_LOAD;
            S_LOAD:  if (w_accept && r_count == LAST_BYTE)  w_state_next = S_CHECK;
            S_CHECK: if (w_accept) w_state_next = (cfg_data == r_xor) ? S_DONE : S_ERR;
            S_DONE:  w_state_next = S_IDLE;
            S_ERR:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_active     <= '0;
            r_configured <= 1'b0;
            r_busy       <= 1'b0;
            r_count      <= '0;
            r_xor        <= '0;
        end else begin
            r_busy <= (w_state_next == S_LOAD) || (w_state_next == S_CHECK);
            if (w_accept && r_state == S_IDLE) begin
                r_count <= '0;
                r_xor   <= '0;
            end
            if (w_load_we) begin
                r_count <= r_count + 9'd1;
                r_xor   <= r_xor ^ cfg_data;
            end
            if (w_commit) begin
                r_active     <= r_shadow;
                r_configured <= 1'b1;
            end
        end
    end

    // One write-enable per shadow byte; the last byte only keeps its low nibble.
    for (genvar gi = 0; gi < N_BYTES - 1; gi++) begin : g_shadow
        always_ff @(posedge clk) begin
            if (w_load_we && r_count == 9'(gi)) begin
                r_shadow[gi*8 +: 8] <= cfg_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_load_we && r_count == LAST_BYTE) begin
            r_shadow[P_BITS-1 -: 4] <= cfg_data[3:0];
        end
    end

    assign brbselect      = r_active[899:0];
    assign bsbselect      = r_active[2627:900];
    assign lbselect       = r_active[2707:2628];
    assign leftioselect   = r_active[2737:2708];
    assign rightioselect  = r_active[2767:2738];
    assign topioselect    = r_active[2797:2768];
    assign bottomioselect = r_active[2827:2798];

    assign cfg_busy   = r_busy;
    assign cfg_done   = (r_state == S_DONE);
    assign cfg_error  = (r_state == S_ERR);
    assign configured = r_configured;

endmodule

// File: tb/tb_fpga_config_loader.sv
// Randomized bench for fpga_config_loader, checked every cycle against a frame-level
// model built from byte queues.
module tb_fpga_config_loader;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    cfg_data;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [899:0]  brbselect;
    logic [1727:0] bsbselect;
    logic [79:0]   lbselect;
    logic [29:0]   leftioselect, rightioselect, topioselect, bottomioselect;
    logic          cfg_busy, cfg_done, cfg_error, configured;

    always #5 clk = ~clk;

    fpga_config_loader #(.SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .rst(rst), .cfg_data(cfg_data), .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready), .brbselect(brbselect), .bsbselect(bsbselect),
        .lbselect(lbselect), .leftioselect(leftioselect), .rightioselect(rightioselect),
        .topioselect(topioselect), .bottomioselect(bottomioselect), .cfg_busy(cfg_busy),
        .cfg_done(cfg_done), .cfg_error(cfg_error), .configured(configured)
    );

    logic [2827:0] w_dut_p;
    assign w_dut_p = {bottomioselect, topioselect, rightioselect, leftioselect,
                      lbselect, bsbselect, brbselect};

    int n_vec  = 0;
    int n_miss = 0;
    int cycle  = 0;
    int done_cycle;

    // Model: frame bytes collected after a sync; evaluated once 355 bytes are present.
    logic [2827:0] m_active;
    logic          m_cfg, m_done, m_err, m_inframe;
    logic [7:0]    m_q[$];
    logic [7:0]    s_q[$];

    task automatic chk_bit(input string name, input logic a, input logic e);
        n_vec++;
        if (a !== e) begin
            n_miss++;
            $display("FAIL %s: got %b, want %b (cycle %0d)", name, a, e, cycle);
        end
    endtask

    task automatic chk_int(input string name, input int a, input int e);
        n_vec++;
        if (a != e) begin
            n_miss++;
            $display("FAIL %s: got %0d, want %0d", name, a, e);
        end
    endtask

    task automatic chk_vec(input string name, input logic [1727:0] a, input logic [1727:0] e);
        int fd;
        n_vec++;
        if (a !== e) begin
            fd = -1;
            for (int i = 0; i < 1728; i++) if (fd < 0 && a[i] !== e[i]) fd = i;
            n_miss++;
            $display("FAIL %s: got %0d ones, want %0d ones, first differing bit %0d (cycle %0d)",
                     name, $countones(a), $countones(e), fd, cycle);
        end
    endtask

    function automatic logic [2827:0] frame_payload();
        logic [2827:0] p;
        for (int i = 0; i < 2828; i++) p[i] = m_q[i/8][i%8];
        return p;
    endfunction

    task automatic model_edge(input logic r, input logic acc, input logic [7:0] d);
        logic [7:0] x;
        if (r) begin
            m_active = '0; m_cfg = 0; m_done = 0; m_err = 0; m_inframe = 0;
            m_q.delete();
        end else begin
            m_done = 0;
            m_err  = 0;
            if (acc) begin
                if (!m_inframe) begin
                    if (d == 8'hA5) begin
                        m_inframe = 1;
                        m_q.delete();
                    end
                end else begin
                    m_q.push_back(d);
                    if (m_q.size() == 355) begin
                        x = 8'h00;
                        for (int i = 0; i < 354; i++) x ^= m_q[i];
                        if (x == m_q[354]) begin
                            m_active = frame_payload();
                            m_cfg    = 1;
                            m_done   = 1;
                        end else begin
                            m_err = 1;
                        end
                        m_inframe = 0;
                    end
                end
            end
        end
    endtask

    task automatic check_outputs();
        chk_bit("cfg_done", cfg_done, m_done);
        chk_bit("cfg_error", cfg_error, m_err);
        chk_bit("configured", configured, m_cfg);
        chk_bit("cfg_busy", cfg_busy, m_inframe);
        chk_vec("brbselect", 1728'(brbselect), 1728'(m_active[899:0]));
        chk_vec("bsbselect", bsbselect, m_active[2627:900]);
        chk_vec("lbselect", 1728'(lbselect), 1728'(m_active[2707:2628]));
        chk_vec("leftioselect", 1728'(leftioselect), 1728'(m_active[2737:2708]));
        chk_vec("rightioselect", 1728'(rightioselect), 1728'(m_active[2767:2738]));
        chk_vec("topioselect", 1728'(topioselect), 1728'(m_active[2797:2768]));
        chk_vec("bottomioselect", 1728'(bottomioselect), 1728'(m_active[2827:2798]));
        if (cfg_done && done_cycle < 0) done_cycle = cycle;
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic r, output logic acc);
        logic exp_ready;
        rst = r; cfg_valid = v; cfg_data = d;
        #1;
        exp_ready = !r && !m_done && !m_err;
        chk_bit("cfg_ready", cfg_ready, exp_ready);
        acc = v && exp_ready;
        @(posedge clk);
        #1;
        cycle++;
        model_edge(r, acc, d);
        check_outputs();
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), 1'b0, acc);
    endtask

    task automatic do_reset();
        logic acc;
        step(1'b1, 8'($urandom), 1'b1, acc);
    endtask

    task automatic send(input int pct);
        logic acc;
        int   tries;
        for (int i = 0; i < s_q.size(); i++) begin
            acc   = 0;
            tries = 0;
            while (!acc) begin
                if ($urandom_range(99) < pct) step(1'b1, s_q[i], 1'b0, acc);
                else                          step(1'b0, 8'($urandom), 1'b0, acc);
                tries++;
                if (tries > 1000) begin
                    n_vec++; n_miss++;
                    $display("FAIL accept_timeout: byte %0d not accepted, want accept within 1000 cycles", i);
                    break;
                end
            end
        end
    endtask

    task automatic build(input logic [7:0] b0, input logic [7:0] mid,
                         input logic [7:0] b353, input logic [7:0] ck);
        s_q.push_back(8'hA5);
        s_q.push_back(b0);
        for (int i = 1; i < 353; i++) s_q.push_back(mid);
        s_q.push_back(b353);
        s_q.push_back(ck);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation still running, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic       acc;
        logic [7:0] x;
        m_active = '0; m_cfg = 0; m_done = 0; m_err = 0; m_inframe = 0;
        rst = 1; cfg_valid = 0; cfg_data = 0;
        done_cycle = -1;
        do_reset();
        do_reset();

        // Full-ones, back-to-back from cycle 0.
        s_q.delete(); build(8'hFF, 8'hFF, 8'h0F, 8'hF0);
        cycle = 0; done_cycle = -1;
        send(100);
        chk_int("done_cycle", done_cycle, 356);
        chk_bit("model_pin_ones", &m_active, 1'b1);
        chk_bit("all_ones", &w_dut_p, 1'b1);
        idle(3);

        // Bad checksum.
        do_reset();
        s_q.delete(); build(8'hFF, 8'hFF, 8'h0F, 8'h00);
        send(100);
        chk_bit("bad_err_pulse", cfg_error, 1'b1);
        chk_bit("bad_outputs_zero", |w_dut_p, 1'b0);
        idle(2);
        chk_bit("bad_configured", configured, 1'b0);

        // Junk before sync.
        do_reset();
        s_q.delete();
        s_q.push_back(8'h00); s_q.push_back(8'h5A); s_q.push_back(8'hFF);
        build(8'h01, 8'h00, 8'h00, 8'h01);
        send(100);
        idle(1);
        chk_vec("junk_brb", 1728'(brbselect), 1728'd1);
        chk_bit("junk_rest_zero", |w_dut_p[2827:1], 1'b0);

        // Backpressure.
        do_reset();
        s_q.delete(); build(8'hFF, 8'hFF, 8'h0F, 8'hF0);
        send(50);
        idle(1);
        chk_bit("bp_all_ones", &w_dut_p, 1'b1);

        // Reset mid-load, then recover.
        s_q.delete(); build(8'h00, 8'h00, 8'h00, 8'h00);
        s_q = s_q[0:100];
        send(100);
        step(1'b1, 8'hFF, 1'b1, acc);
        chk_bit("midreset_busy", cfg_busy, 1'b0);
        chk_bit("midreset_zero", |w_dut_p, 1'b0);
        s_q.delete(); build(8'hFF, 8'hFF, 8'h0F, 8'hF0);
        send(100);
        idle(1);
        chk_bit("recover_ones", &w_dut_p, 1'b1);

        // Reload over an active configuration.
        s_q.delete(); build(8'h00, 8'h00, 8'h08, 8'h08);
        send(80);
        idle(1);
        chk_vec("reload_bottom", 1728'(bottomioselect), 1728'(30'h2000_0000));
        chk_bit("reload_rest_zero", |w_dut_p[2797:0], 1'b0);
        chk_bit("reload_configured", configured, 1'b1);

        // Random frames: random payload, junk, checksum sometimes corrupted, occasional reset.
        for (int t = 0; t < 8; t++) begin
            s_q.delete();
            for (int j = 0; j < $urandom_range(3); j++) s_q.push_back(8'($urandom));
            s_q.push_back(8'hA5);
            x = 8'h00;
            for (int j = 0; j < 354; j++) begin
                s_q.push_back(8'($urandom));
                x ^= s_q[s_q.size()-1];
            end
            if ($urandom_range(9) < 3) x ^= 8'($urandom_range(255, 1));
            s_q.push_back(x);
            send(int'($urandom_range(100, 30)));
            idle(int'($urandom_range(3)));
            if ($urandom_range(9) == 0) do_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
